// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Baud counter: tick marks the last clk cycle of each serial bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    // One-bit floor keeps the counter legal when CLKS_PER_BIT=1; it then stays at 0.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (clear || tick) cnt <= '0;
        else                    cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/serial_tx.sv
// Start/data/stop serial transmitter with valid/ready word intake, LSB first.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift_reg, shift_n, shifted;
    logic [BCW-1:0]    bit_cnt, bit_cnt_n;
    logic              tx_out_n;
    logic              tick, hs;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_out    <= IDLE_LEVEL;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_cnt_n;
            tx_out    <= tx_out_n;
        end
    end

    assign shifted = shift_reg >> 1;

    // tx_out is loaded with the level of the upcoming cycle so the pin comes straight off a flop.
    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        bit_cnt_n = bit_cnt;
        tx_out_n  = tx_out;
        done      = 1'b0;
        tx_ready  = 1'b0;
        busy      = (state != IDLE);
        hs        = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                tx_out_n = IDLE_LEVEL;
            end
            START: begin
                if (tick) begin
                    state_n  = DATA;
                    tx_out_n = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                        tx_out_n  = STOP_LEVEL;
                    end else begin
                        bit_cnt_n = bit_cnt + BCW'(1);
                        shift_n   = shifted;
                        tx_out_n  = shifted[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done     = 1'b1;
                    tx_ready = 1'b1;
                    state_n  = IDLE;
                    tx_out_n = IDLE_LEVEL;
                end
            end
            default: state_n = IDLE;
        endcase
        hs = tx_valid & tx_ready;
        // A word taken on the final stop cycle starts the next frame with no idle gap.
        if (hs) begin
            state_n   = START;
            shift_n   = tx_data;
            bit_cnt_n = '0;
            tx_out_n  = START_LEVEL;
        end
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Frame transmitter that turns a 16-bit parallel word into a start/data/stop serial bit stream on a single line. It drives the bit sequence that a downstream single-bit capture stage (clocked D flip-flop sampler) latches. It sits between the CPU's output register and the serial pin. It accepts words over a valid/ready handshake and shifts them out LSB first at a programmable bit period.

## Interface
- DATA_W, 16, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (≥1)
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- tx_data  input  DATA_W  word to send; sampled only on handshake
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word this cycle
- tx_out  output  1  serial line; idle level 1
- busy  output  1  frame in progress (START, DATA or STOP)
- done  output  1  one-cycle pulse marking the final cycle of a stop bit

## Operation
- Reset (rst_n low, asynchronous): state IDLE, tx_out=1, busy=0, done=0, tx_ready=1 after release, shift register, bit counter and baud counter cleared.
- States and transitions:
  - IDLE → START on handshake (tx_valid & tx_ready).
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after DATA_W bits.
  - STOP → IDLE after CLKS_PER_BIT cycles, or STOP → START if a handshake occurs in the final STOP cycle.
- Handshake: transfer when tx_valid & tx_ready at a posedge. tx_data is latched into the shift register and not sampled again until the next transfer. Changes to tx_data mid-frame have no effect.
- tx_ready=1 in IDLE and in the final cycle of STOP (the same cycle as done). Otherwise 0.
- tx_out per state:
  - START: 0.
  - DATA: shift_reg[0], shift right by one at each bit boundary.
  - STOP: 1.
  - IDLE: 1.
- tx_out is registered and never glitches.
- Bit counter width is $clog2(DATA_W+1). Baud counter width is $clog2(CLKS_PER_BIT). Both wrap to 0 at terminal count with no overflow.
- tx_valid high with tx_ready low is held off. The word is not lost as long as the source keeps valid asserted (standard valid/ready rule).

## Timing
- Handshake at edge N → tx_out=0 from edge N+1.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles. With defaults: 72 cycles.
- done is high for exactly 1 cycle: the last cycle of STOP.
- Back-to-back frames: with a handshake on the done cycle, the next start bit begins on the following edge, with zero idle gap. Otherwise there is at least 1 IDLE cycle (tx_out=1).
- CLKS_PER_BIT=1: each bit lasts 1 cycle, and the baud counter is constant 0/unused.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronous), and the frame is abandoned. After release the block is in IDLE with tx_ready=1.

## Structure
- Shared package serial_pkg holds:
  - the state typedef (IDLE, START, DATA, STOP, 2-bit);
  - localparam IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One natural sub-module, bit_timer: parameter CLKS_PER_BIT, inputs clk/rst_n/clear, output tick (high on the last cycle of each bit period).
- The top level contains the FSM, shift register and bit counter.

## Test plan
- Single word: after reset, send 16'hA5C3 with a 1-cycle valid pulse.
  - tx_out over 72 cycles is 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
  - done pulses at cycle 72.
  - tx_ready is 0 from cycles 1–71.
- Back-to-back: hold tx_valid with 16'h0001 then 16'hFFFF.
  - Second start bit follows the first stop bit with no idle cycle.
  - Total of 144 busy cycles.
- Hold-off: assert tx_valid with 16'h1234 mid-frame.
  - Not accepted until the done cycle.
  - Changing tx_data to 16'h5678 during the current frame does not alter the bits on the line.
- Reset mid-frame: drop rst_n during DATA bit 5.
  - tx_out=1, busy=0 and done=0 in the same cycle.
  - After release, 16'h00FF is sent correctly.
- Parameter corner: DATA_W=8, CLKS_PER_BIT=1, send 8'h81.
  - 10-cycle frame: 0,1,0,0,0,0,0,0,1,1.
- Idle line: no tx_valid for 50 cycles after reset.
  - tx_out stays 1, busy stays 0, done is never asserted.
